// File: rtl/parity_serial_checker.sv
// Serial parity checker: deserialises LSB-first frames of DATA_W data bits plus one
// parity bit, checks parity and presents each word on a one-entry valid/ready register.
module parity_serial_checker #(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sin,
    input  logic                 sin_valid,
    input  logic                 sof,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_perr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 overrun,
    input  logic                 err_clr,
    output logic                 frame_abort,
    output logic                 busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [DATA_W-1:0]      shift_q;
    logic [DATA_W-1:0]      shift_d;
    logic [DATA_W-1:0]      out_data_q;
    logic                   out_perr_q;
    logic                   out_valid_q;
    logic [ERR_CNT_W-1:0]   err_count_q;
    logic                   overrun_q;
    logic                   frame_abort_q;

    logic                   in_shift;
    logic                   last_bit;
    logic                   frame_done;
    logic                   parity_err;
    logic                   reg_free;
    logic                   load;

    // Bits enter at the MSB and move right, so after DATA_W bits the first bit sits at bit 0.
    always_comb begin
        shift_d    = {sin, shift_q[DATA_W-1:1]};
        in_shift   = (state_q == SHIFT);
        last_bit   = (bit_cnt_q == LAST_BIT);
        frame_done = sin_valid & ~sof & in_shift & last_bit;
        parity_err = ((^shift_q) ^ sin) != ODD_PARITY;
        reg_free   = ~out_valid_q | out_ready;
        load       = frame_done & reg_free;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            out_data_q    <= '0;
            out_perr_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            err_count_q   <= '0;
            overrun_q     <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            frame_abort_q <= 1'b0;
            if (sin_valid) begin
                if (sof) begin
                    shift_q       <= shift_d;
                    bit_cnt_q     <= CNT_ONE;
                    state_q       <= SHIFT;
                    frame_abort_q <= in_shift;
                end else if (in_shift) begin
                    if (last_bit) begin
                        bit_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + CNT_ONE;
                    end
                end
            end

            if (load) begin
                out_data_q  <= shift_q;
                out_perr_q  <= parity_err;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            // Clear takes priority over a same-cycle increment or overrun.
            if (err_clr) begin
                err_count_q <= '0;
                overrun_q   <= 1'b0;
            end else begin
                if (load && parity_err && (err_count_q != {ERR_CNT_W{1'b1}}))
                    err_count_q <= err_count_q + 1'b1;
                if (frame_done && !reg_free)
                    overrun_q <= 1'b1;
            end
        end
    end

    assign out_data    = out_data_q;
    assign out_perr    = out_perr_q;
    assign out_valid   = out_valid_q;
    assign err_count   = err_count_q;
    assign overrun     = overrun_q;
    assign frame_abort = frame_abort_q;
    assign busy        = in_shift;

endmodule

// File: doc/parity_serial_checker.md
# parity_serial_checker

Serial receive-side companion to the team's 9-bit parity generator. It deserialises LSB-first frames of DATA_W data bits followed by one parity bit and checks the parity under the configured scheme. It presents each checked word on a one-entry valid/ready output register and keeps a saturating parity-error counter and a sticky overrun flag for status readback. It sits between the serial line sampler and the word-level consumer.

## Interface
- DATA_W, 8, number of data bits per frame; frame length is DATA_W+1.
- ODD_PARITY, 0, 0: a frame is good when XOR of all DATA_W+1 bits is 0 (even scheme); 1: good when the XOR is 1 (odd scheme).
- ERR_CNT_W, 8, width of the parity-error counter.

- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- sin  in  1  serial data bit, sampled only when sin_valid=1.
- sin_valid  in  1  qualifies sin for one cycle.
- sof  in  1  start-of-frame; meaningful only with sin_valid=1; marks sin as data bit 0.
- out_data  out  DATA_W  checked data word, LSB is the first received bit.
- out_perr  out  1  1 when the frame in out_data failed parity.
- out_valid  out  1  out_data and out_perr hold a word.
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.
- err_count  out  ERR_CNT_W  count of parity-failing frames loaded into the output register, saturating.
- overrun  out  1  sticky; a completed frame was dropped because the output register was full.
- err_clr  in  1  one-cycle clear of err_count and overrun.
- frame_abort  out  1  one-cycle pulse: sof arrived while a frame was partially received.
- busy  out  1  1 while in SHIFT.

## Operation
- States: IDLE, SHIFT. bit_cnt counts received bits 0..DATA_W.
- IDLE: sin_valid & sof -> store sin as bit 0, bit_cnt=1, go SHIFT. sin_valid without sof is ignored.
- SHIFT, sin_valid & !sof, bit_cnt<DATA_W: store sin at position bit_cnt, bit_cnt+1.
- SHIFT, sin_valid & !sof, bit_cnt==DATA_W (parity bit): compute err = (XOR of data bits ^ sin) != ODD_PARITY; frame complete; go IDLE.
- SHIFT, sin_valid & sof: discard partial frame; pulse frame_abort; store sin as bit 0, bit_cnt=1, stay SHIFT.
- Frame complete with register free (out_valid=0, or out_ready=1 in the same cycle): load out_data/out_perr, out_valid=1; if err, increment err_count unless it is already all-ones.
- Frame complete with out_valid=1 & out_ready=0: drop the frame; set overrun; out_data and out_perr unchanged; err_count unchanged.
- Transfer with no frame completing: out_valid -> 0 next cycle; out_data holds its stale value.
- err_clr: err_count=0 and overrun=0 next cycle. Clear wins over a same-cycle increment or overrun set.
- Reset (any cycle, including mid-frame): state IDLE, bit_cnt=0, out_data=0, out_perr=0, out_valid=0, err_count=0, overrun=0, frame_abort=0, busy=0. The partial frame is lost.

## Timing
- Latency: out_valid rises on the edge that samples the parity bit. The word is visible in the cycle after the parity bit's sin_valid cycle.
- Back-to-back sin_valid every cycle is supported. Minimum frame spacing is 0 idle cycles: sof may accompany the bit immediately after the parity bit.
- out_valid, once high, stays high with stable out_data/out_perr until a transfer.
- frame_abort is registered and high for exactly one cycle per abort.
- busy, err_count and overrun are registered and update on the edge following the causing event.

## Test plan
- DATA_W=8, ODD_PARITY=0; frame 0xA5, parity bit 0, out_ready=1 -> out_data=0xA5, out_perr=0, out_valid one cycle, err_count=0.
- Frame 0x01 with parity bit 0 -> out_perr=1, err_count=1. Then pulse err_clr -> err_count=0.
- out_ready tied 1; frames 0xFF/p0 and 0x00/p0 back-to-back with no gap -> two transfers, both out_perr=0, no overrun.
- sof, then 4 bits, then sof plus a full frame 0x3C/p0 -> frame_abort pulses once; one word 0x3C, out_perr=0.
- out_ready=0; frames 0x11/p0 and 0x22/p0 -> out_data stays 0x11, overrun=1. Raise out_ready -> 0x11 transferred. err_clr -> overrun=0.
- ERR_CNT_W=2; five bad frames -> err_count saturates at 3. Assert rst_n=0 after 5 bits of a sixth frame -> all outputs 0; the next full frame is received correctly.
